instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit that acts as the requester on the IMem read port. It holds the program counter, issues one word request per cycle to IMem, and tags each returned word with its PC and fault status. Results go into a small FIFO toward decode with a valid/ready handshake. It also handles PC redirects from execute (branch/jump/trap), killing stale in-flight and buffered fetches.

## Interface
- ADDR_W, memory_pkg::MEM_ADDR_WIDTH, byte-address width of IMem port and PC
- WORD_W, memory_pkg::MEM_WORD_WIDTH (32), instruction width
- RESET_PC, 0, first fetch address after reset; must be 4-byte aligned
- FIFO_DEPTH, 2, output buffer entries; legal range 2..8

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  IMem read request, registered
- imem_addr  out  ADDR_W  IMem byte address, registered
- imem_addr_err  in  1  IMem address error for the request sampled on the previous edge
- imem_data  in  WORD_W  IMem read data for the request sampled on the previous edge
- redirect_valid  in  1  load new PC this cycle; has priority over everything
- redirect_pc  in  ADDR_W  new PC
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode accepts head
- inst_data  out  WORD_W  instruction word (0 when inst_fault=1)
- inst_pc  out  ADDR_W  PC of the head instruction
- inst_fault  out  1  head is a fetch fault (IMem addr_err or misaligned PC)

## Operation
- IMem contract: a request with imem_req=1 sampled at edge E returns imem_data/imem_addr_err valid during the cycle after E, and they are captured at edge E+1. At most one request is in flight at a time, tracked by the inflight bit and inflight_pc.
- States: FETCH and HALTED. Reset enters FETCH with pc=RESET_PC.
- FETCH issue rule: drive imem_req=1 with imem_addr=pc when count + inflight - pop < FIFO_DEPTH. Here pop = inst_valid & inst_ready and count is the FIFO occupancy. On each issue, pc += 4, which wraps modulo 2^ADDR_W.
- Response: when inflight is set and not killed, push {imem_data, inflight_pc, imem_addr_err} into the FIFO.
  - If imem_addr_err=1, push data=0 with fault=1, go to HALTED, and stop issuing.
- Misaligned PC (pc[1:0]≠0) in FETCH: do not request IMem. Push a fault entry with inst_pc=pc and data=0, then go to HALTED.
- HALTED: no requests are issued. The FIFO still drains normally. Only redirect_valid leaves HALTED.
- Redirect (any state):
  - Flush the FIFO, so count becomes 0 and inst_valid=0 next cycle.
  - Mark the current in-flight response killed; its data is discarded and no push happens.
  - Set pc=redirect_pc and go to FETCH.
  - No request is issued in the redirect cycle.
- Simultaneous events:
  - Redirect + pop: the pop is honoured (decode consumed it) and the flush still applies.
  - Redirect + response arriving in the same cycle: the response is dropped.
  - Push + pop on a full FIFO is legal, and count stays unchanged.
- The FIFO is an ordinary circular buffer with read/write pointers. inst_* is driven from the head entry and is stable while inst_valid=1 and inst_ready=0.

## Timing
- Reset values (asynchronous):
  - imem_req=0, imem_addr=RESET_PC
  - inst_valid=0, inst_data=0, inst_pc=0, inst_fault=0
  - count=0, inflight=0, state=FETCH
- First request: imem_req=1, imem_addr=RESET_PC at the first rising edge after rst_n deasserts.
- Fetch latency: issue at edge E, data captured at E+1, inst_valid=1 after E+1 (2 edges from issue).
- Redirect at edge R: new request at R+1, inst_valid for the target after R+2. No stale instruction is visible after R.
- Throughput: 1 instruction per cycle with inst_ready held high.
- Backpressure: no more than FIFO_DEPTH entries are ever outstanding (buffered plus in flight). No IMem response is ever lost.
- rst_n asserted mid-operation clears everything immediately, including in-flight state. The late IMem response is ignored.

## Test plan
- Image word at address 4i = 0x00100013+i.
  - Stimulus: reset, then inst_ready=1 for 10 cycles.
  - Required: PCs 0x0,0x4,…,0x24 in order, consecutive inst_valid cycles, data matches the image, fault=0.
- Backpressure:
  - Stimulus: inst_ready=0 for 6 cycles mid-stream.
  - Required: inst_valid stays 1, head stable, imem_req low once the outstanding count hits FIFO_DEPTH, no skipped or duplicated PC after release.
- Redirect with in flight:
  - Stimulus: redirect_pc=0x40 while PCs 0x8/0xC are buffered or in flight.
  - Required: next valid inst_pc is 0x40 with data 0x00100023, and no 0x8/0xC appears afterwards.
- Misaligned redirect:
  - Stimulus: redirect_pc=0x42.
  - Required: one entry with inst_pc=0x42, inst_fault=1, data=0; no imem_req; HALTED until the next redirect.
- Address error:
  - Stimulus: redirect to 0x00010000 (out of range, IMem asserts addr_err).
  - Required: fault entry with inst_pc=0x00010000, fetching halts. A later redirect to 0x0 resumes at data 0x00100013.
- Reset mid-stream:
  - Stimulus: pulse rst_n low between clock edges while a request is in flight.
  - Required: outputs drop to reset values immediately, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, drives the IMem read port with one
// request per cycle, and queues tagged instructions toward decode through a
// small valid/ready FIFO. Execute-stage redirects flush everything stale.

package memory_pkg;
  localparam int MEM_ADDR_WIDTH = 32;
  localparam int MEM_WORD_WIDTH = 32;
endpackage

module instr_fetch #(
  parameter int                ADDR_W     = memory_pkg::MEM_ADDR_WIDTH,
  parameter int                WORD_W     = memory_pkg::MEM_WORD_WIDTH,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_addr_err,
  input  logic [WORD_W-1:0] imem_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [WORD_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]    DEPTH_EXT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 8) begin : g_bad_depth
    $error("instr_fetch: FIFO_DEPTH must be within 2..8");
  end
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("instr_fetch: RESET_PC must be 4-byte aligned");
  end

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [ADDR_W-1:0] pc;
    logic              fault;
  } entry_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  entry_t            fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  entry_t            head;
  entry_t            push_entry;

  logic              issue;
  logic              push;
  logic              pop;
  logic              inflight;
  logic              resp_valid;
  logic              resp_fault;
  logic              misaligned;
  logic [CNT_W:0]    outstanding;
  logic [CNT_W:0]    kept;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
  endfunction

  // The registered request is exactly the single in-flight request: its
  // response is on imem_data during the cycle after it was issued.
  assign inflight   = imem_req;
  assign pop        = inst_valid & inst_ready;
  assign resp_valid = inflight & ~redirect_valid;
  assign resp_fault = resp_valid & imem_addr_err;
  assign misaligned = (pc_q[1:0] != 2'b00);

  // Entries still held after this edge, and that plus the in-flight one.
  assign kept        = {1'b0, count} - (CNT_W + 1)'(pop);
  assign outstanding = kept + (CNT_W + 1)'(inflight);

  // Next-state, PC advance, issue decision and FIFO push selection.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    issue      = 1'b0;
    push       = 1'b0;
    push_entry = '0;

    if (redirect_valid) begin
      // Flush and kill: the response arriving now is dropped, nothing issues.
      state_d = FETCH;
      pc_d    = redirect_pc;
    end else begin
      if (resp_valid) begin
        push             = 1'b1;
        push_entry.pc    = imem_addr;
        push_entry.fault = imem_addr_err;
        push_entry.data  = imem_addr_err ? '0 : imem_data;
      end

      unique case (state_q)
        FETCH: begin
          if (resp_fault) begin
            state_d = HALTED;
          end else if (misaligned) begin
            // Only reachable right after a redirect, so nothing is in flight
            // and the FIFO is empty; the guard keeps the single push port safe.
            if (!inflight && (kept < DEPTH_EXT)) begin
              push             = 1'b1;
              push_entry.pc    = pc_q;
              push_entry.fault = 1'b1;
              state_d          = HALTED;
            end
          end else if (outstanding < DEPTH_EXT) begin
            issue = 1'b1;
            pc_d  = pc_q + PC_STEP;
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // State, PC and the registered IMem request port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q  <= state_d;
      pc_q     <= pc_d;
      imem_req <= issue;
      if (issue) begin
        imem_addr <= pc_q;
      end
    end
  end

  // Output FIFO: circular buffer with read/write pointers and an occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      // NOTE: the storage is reset too, because the head entry drives the
      // outputs directly and those must read zero out of reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= push_entry;
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign head       = fifo_mem[rd_ptr];
  assign inst_valid = (count != '0);
  assign inst_data  = head.data;
  assign inst_pc    = head.pc;
  assign inst_fault = head.fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, redirects,
// misaligned and out-of-range fetches, and an asynchronous mid-stream reset.

module tb_instr_fetch;

  localparam int          ADDR_W     = 32;
  localparam int          WORD_W     = 32;
  localparam logic [31:0] IMEM_LIMIT = 32'h0000_1000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_addr_err;
  logic [WORD_W-1:0] imem_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [WORD_W-1:0] inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_fault;

  int n_checks = 0;
  int n_pass   = 0;

  instr_fetch #(
    .ADDR_W     (ADDR_W),
    .WORD_W     (WORD_W),
    .RESET_PC   (32'h0),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_addr_err  (imem_addr_err),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  always #5 clk = ~clk;

  // IMem model: answers the registered request during the following cycle.
  // Out-of-range addresses raise addr_err and return junk data.
  always_comb begin
    imem_addr_err = (imem_addr >= IMEM_LIMIT);
    imem_data     = imem_addr_err ? 32'hBAD0_BAD0 : 32'h0010_0013 + (imem_addr >> 2);
  end

  function automatic logic [31:0] img(input int i);
    return 32'h0010_0013 + 32'(i);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic expect_head(input string tag, input logic [31:0] pc,
                             input logic [31:0] data, input logic fault);
    check({tag, "/valid"}, 64'(inst_valid), 64'(1'b1));
    check({tag, "/pc"},    64'(inst_pc),    64'(pc));
    check({tag, "/data"},  64'(inst_data),  64'(data));
    check({tag, "/fault"}, 64'(inst_fault), 64'(fault));
  endtask

  task automatic expect_reset_values(input string tag);
    check({tag, "/req"},   64'(imem_req),   64'(1'b0));
    check({tag, "/addr"},  64'(imem_addr),  64'(32'h0));
    check({tag, "/valid"}, 64'(inst_valid), 64'(1'b0));
    check({tag, "/data"},  64'(inst_data),  64'(32'h0));
    check({tag, "/pc"},    64'(inst_pc),    64'(32'h0));
    check({tag, "/fault"}, 64'(inst_fault), 64'(1'b0));
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;

    // Reset values, then the first request one edge after release.
    repeat (2) @(negedge clk);
    expect_reset_values("reset");
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    @(negedge clk);
    check("first_req",   64'(imem_req),   64'(1'b1));
    check("first_addr",  64'(imem_addr),  64'(32'h0));
    check("first_valid", 64'(inst_valid), 64'(1'b0));

    // Streaming: one instruction per cycle, PCs 0x0..0x24.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      expect_head("stream", 32'(4 * i), img(i), 1'b0);
      check("stream_req", 64'(imem_req), 64'(1'b1));
    end

    // Backpressure: head 0x28 held for 6 cycles, requests stop at depth.
    @(negedge clk);
    expect_head("bp_head", 32'h28, img(10), 1'b0);
    inst_ready = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      expect_head("bp_hold", 32'h28, img(10), 1'b0);
      check("bp_req", 64'(imem_req), 64'(1'b0));
    end
    inst_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      expect_head("bp_release", 32'(32'h28 + 4 * k), img(10 + k), 1'b0);
    end

    // Redirect to 0x8, stall so 0x8 is buffered and 0xC in flight, then 0x40.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    inst_ready     = 1'b0;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("rd8_flush_valid", 64'(inst_valid), 64'(1'b0));
    check("rd8_no_req",      64'(imem_req),   64'(1'b0));
    @(negedge clk);
    check("rd8_req",  64'(imem_req),  64'(1'b1));
    check("rd8_addr", 64'(imem_addr), 64'(32'h8));
    @(negedge clk);
    expect_head("rd8_head", 32'h8, img(2), 1'b0);
    check("rdC_addr", 64'(imem_addr), 64'(32'hC));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("rd40_flush_valid", 64'(inst_valid), 64'(1'b0));
    check("rd40_no_req",      64'(imem_req),   64'(1'b0));
    @(negedge clk);
    check("rd40_req",   64'(imem_req),   64'(1'b1));
    check("rd40_addr",  64'(imem_addr),  64'(32'h40));
    check("rd40_valid", 64'(inst_valid), 64'(1'b0));
    @(negedge clk);
    expect_head("rd40_head", 32'h40, 32'h0010_0023, 1'b0);
    inst_ready = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      expect_head("rd40_next", 32'(32'h40 + 4 * k), img(16 + k), 1'b0);
    end

    // Misaligned redirect: one fault entry, no request, then halted.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("mis_flush_valid", 64'(inst_valid), 64'(1'b0));
    check("mis_no_req0",     64'(imem_req),   64'(1'b0));
    @(negedge clk);
    expect_head("mis_fault", 32'h42, 32'h0, 1'b1);
    check("mis_no_req1", 64'(imem_req), 64'(1'b0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("mis_halt_valid", 64'(inst_valid), 64'(1'b0));
      check("mis_halt_req",   64'(imem_req),   64'(1'b0));
    end

    // Out-of-range fetch: addr_err becomes a fault entry and fetch halts.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0001_0000;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("aerr_no_req0", 64'(imem_req), 64'(1'b0));
    @(negedge clk);
    check("aerr_req",   64'(imem_req),   64'(1'b1));
    check("aerr_addr",  64'(imem_addr),  64'(32'h0001_0000));
    check("aerr_valid", 64'(inst_valid), 64'(1'b0));
    @(negedge clk);
    expect_head("aerr_fault", 32'h0001_0000, 32'h0, 1'b1);
    check("aerr_no_req1", 64'(imem_req), 64'(1'b0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("aerr_halt_valid", 64'(inst_valid), 64'(1'b0));
      check("aerr_halt_req",   64'(imem_req),   64'(1'b0));
    end

    // Redirect to 0x0 resumes fetching.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    check("resume_no_req", 64'(imem_req), 64'(1'b0));
    @(negedge clk);
    check("resume_req",  64'(imem_req),  64'(1'b1));
    check("resume_addr", 64'(imem_addr), 64'(32'h0));
    @(negedge clk);
    expect_head("resume_head0", 32'h0, img(0), 1'b0);
    @(negedge clk);
    expect_head("resume_head1", 32'h4, img(1), 1'b0);

    // Asynchronous reset pulse between edges with a request in flight.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 expect_reset_values("async_rst");
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_valid", 64'(inst_valid), 64'(1'b0));
    check("post_rst_req",   64'(imem_req),   64'(1'b0));
    @(negedge clk);
    check("restart_req",  64'(imem_req),  64'(1'b1));
    check("restart_addr", 64'(imem_addr), 64'(32'h0));
    @(negedge clk);
    expect_head("restart_head0", 32'h0, img(0), 1'b0);
    @(negedge clk);
    expect_head("restart_head1", 32'h4, img(1), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
